// File: rtl/wave_dac_serializer.sv
// ============================================================================
// Module   : wave_dac_serializer
// Brief    : Per-channel sample slots, round-robin scheduled onto a framed SPI
//            link (address MSB-first, then sample).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wave_dac_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 2,
    parameter int ADDR_BITS  = 1,
    parameter int CLK_DIV    = 1,
    parameter int LSB_FIRST  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [ADDR_BITS-1:0]  channel_i,
    input  logic                  data_valid_strobe_i,
    input  logic                  clear_overrun_i,
    output logic                  sclk_o,
    output logic                  sdo_o,
    output logic                  cs_o,
    output logic                  busy_o,
    output logic                  frame_done_strobe_o,
    output logic                  overrun_o
);

    localparam int FRAME_BITS = ADDR_BITS + DATA_WIDTH;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [7:0]           DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]     LAST_BIT   = BIT_W'(FRAME_BITS - 1);
    localparam logic [ADDR_BITS-1:0] LAST_CH    = ADDR_BITS'(CHANNELS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SHIFT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              div_q, div_d;
    logic [BIT_W-1:0]        bit_q, bit_d;
    logic                    high_q, high_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic                    sclk_q, sclk_d;
    logic                    sdo_q, sdo_d;
    logic                    cs_q, cs_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    ovr_q, ovr_d;
    logic [CHANNELS-1:0]     pending_q, pending_d;
    logic [ADDR_BITS-1:0]    last_q, last_d;
    logic [DATA_WIDTH-1:0]   slot_q [CHANNELS];

    logic                    w_cap, w_found, w_load, w_ovr;
    logic [ADDR_BITS-1:0]    w_sel;
    logic [DATA_WIDTH-1:0]   w_sample, w_rev, w_ord;
    logic [FRAME_BITS-1:0]   w_frame;

    // Out-of-range channels are dropped before touching slots or pending bits.
    assign w_cap  = data_valid_strobe_i && (32'(channel_i) < CHANNELS);
    assign w_load = (state_q == S_IDLE) && enable_i && w_found;

    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (!w_found && pending_q[c] &&
                    (c == (int'(last_q) + 1 + i) % CHANNELS)) begin
                    w_found = 1'b1;
                    w_sel   = ADDR_BITS'(c);
                end
            end
        end
    end

    always_comb begin
        w_sample = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_sel == ADDR_BITS'(c)) w_sample = slot_q[c];
        end
        w_rev = '0;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            w_rev[b] = w_sample[DATA_WIDTH-1-b];
        end
        w_ord   = (LSB_FIRST != 0) ? w_rev : w_sample;
        w_frame = {w_sel, w_ord};
    end

    // A slot handed to the shifter this cycle may be refilled without overrun.
    always_comb begin
        pending_d = pending_q;
        w_ovr     = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_load && (w_sel == ADDR_BITS'(c))) pending_d[c] = 1'b0;
            if (w_cap && (channel_i == ADDR_BITS'(c))) begin
                pending_d[c] = 1'b1;
                if (pending_q[c] && !(w_load && (w_sel == ADDR_BITS'(c)))) w_ovr = 1'b1;
            end
        end
        ovr_d = w_ovr ? 1'b1 : (clear_overrun_i ? 1'b0 : ovr_q);
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        high_d  = high_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        sdo_d   = sdo_q;
        cs_d    = cs_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_load) begin
                    state_d = S_SETUP;
                    div_d   = DIV_RELOAD;
                    shreg_d = w_frame;
                    cs_d    = 1'b0;
                    sclk_d  = 1'b1;
                    sdo_d   = w_frame[FRAME_BITS-1];
                    last_d  = w_sel;
                end
            end
            S_SETUP: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else begin
                    state_d = S_SHIFT;
                    div_d   = DIV_RELOAD;
                    bit_d   = '0;
                    high_d  = 1'b0;
                    sclk_d  = 1'b0;
                    sdo_d   = shreg_q[FRAME_BITS-1];
                end
            end
            S_SHIFT: begin
                if (div_q != 8'd0) begin
                    div_d = div_q - 8'd1;
                end else if (!high_q) begin
                    high_d = 1'b1;
                    sclk_d = 1'b1;
                    div_d  = DIV_RELOAD;
                end else if (bit_q == LAST_BIT) begin
                    state_d = S_HOLD;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    div_d   = DIV_RELOAD;
                end else begin
                    // Data changes on the falling sclk edge, stable across the rise.
                    bit_d   = bit_q + 1'b1;
                    high_d  = 1'b0;
                    sclk_d  = 1'b0;
                    shreg_d = shreg_q << 1;
                    sdo_d   = shreg_q[FRAME_BITS-2];
                    div_d   = DIV_RELOAD;
                end
            end
            S_HOLD: begin
                if (div_q != 8'd0) div_d = div_q - 8'd1;
                else               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            bit_q     <= '0;
            high_q    <= 1'b0;
            shreg_q   <= '0;
            sclk_q    <= 1'b1;
            sdo_q     <= 1'b0;
            cs_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            pending_q <= '0;
            last_q    <= LAST_CH;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            high_q    <= high_d;
            shreg_q   <= shreg_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
            pending_q <= pending_d;
            last_q    <= last_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_cap && (channel_i == ADDR_BITS'(c))) slot_q[c] <= data_i;
        end
    end

    assign sclk_o              = sclk_q;
    assign sdo_o               = sdo_q;
    assign cs_o                = cs_q;
    assign busy_o              = busy_q;
    assign frame_done_strobe_o = done_q;
    assign overrun_o           = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_wave_dac_serializer.sv
// ============================================================================
// Module   : tb_wave_dac_serializer
// Brief    : Directed-vector bench for wave_dac_serializer (three configs).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wave_dac_serializer;

    logic       clk = 1'b0;
    logic       rst_n, en, clr;
    logic [7:0] data;
    logic       ch;
    logic [1:0] ch_c;
    logic       stb_a, stb_b, stb_c;

    logic sclk_a, sdo_a, cs_a, busy_a, done_a, ovr_a;
    logic sclk_b, sdo_b, cs_b, busy_b, done_b, ovr_b;
    logic sclk_c, sdo_c, cs_c, busy_c, done_c, ovr_c;

    always #5 clk = ~clk;

    wave_dac_serializer #(.DATA_WIDTH(8), .CHANNELS(2), .ADDR_BITS(1), .CLK_DIV(1), .LSB_FIRST(0)) u_dut_a (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en), .data_i(data), .channel_i(ch),
        .data_valid_strobe_i(stb_a), .clear_overrun_i(clr), .sclk_o(sclk_a), .sdo_o(sdo_a),
        .cs_o(cs_a), .busy_o(busy_a), .frame_done_strobe_o(done_a), .overrun_o(ovr_a));

    wave_dac_serializer #(.DATA_WIDTH(8), .CHANNELS(2), .ADDR_BITS(1), .CLK_DIV(3), .LSB_FIRST(1)) u_dut_b (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en), .data_i(data), .channel_i(ch),
        .data_valid_strobe_i(stb_b), .clear_overrun_i(clr), .sclk_o(sclk_b), .sdo_o(sdo_b),
        .cs_o(cs_b), .busy_o(busy_b), .frame_done_strobe_o(done_b), .overrun_o(ovr_b));

    wave_dac_serializer #(.DATA_WIDTH(8), .CHANNELS(2), .ADDR_BITS(2), .CLK_DIV(1), .LSB_FIRST(0)) u_dut_c (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en), .data_i(data), .channel_i(ch_c),
        .data_valid_strobe_i(stb_c), .clear_overrun_i(clr), .sclk_o(sclk_c), .sdo_o(sdo_c),
        .cs_o(cs_c), .busy_o(busy_c), .frame_done_strobe_o(done_c), .overrun_o(ovr_c));

    int   inst = 0;
    logic m_sclk, m_sdo, m_cs, m_busy, m_done, m_ovr;
    assign m_sclk = (inst == 0) ? sclk_a : (inst == 1) ? sclk_b : sclk_c;
    assign m_sdo  = (inst == 0) ? sdo_a  : (inst == 1) ? sdo_b  : sdo_c;
    assign m_cs   = (inst == 0) ? cs_a   : (inst == 1) ? cs_b   : cs_c;
    assign m_busy = (inst == 0) ? busy_a : (inst == 1) ? busy_b : busy_c;
    assign m_done = (inst == 0) ? done_a : (inst == 1) ? done_b : done_c;
    assign m_ovr  = (inst == 0) ? ovr_a  : (inst == 1) ? ovr_b  : ovr_c;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic strobe(input int which, input logic [1:0] c, input logic [7:0] d);
        @(negedge clk);
        data = d; ch = c[0]; ch_c = c;
        stb_a = (which == 0); stb_b = (which == 1); stb_c = (which == 2);
        @(negedge clk);
        stb_a = 1'b0; stb_b = 1'b0; stb_c = 1'b0;
    endtask

    // Two back-to-back strobes on instance A; returns one cycle after the second.
    task automatic strobe2(input logic c0, input logic [7:0] d0, input logic c1, input logic [7:0] d1);
        @(negedge clk);
        data = d0; ch = c0; stb_a = 1'b1;
        @(negedge clk);
        data = d1; ch = c1;
        @(negedge clk);
        stb_a = 1'b0;
    endtask

    int          f_wait, f_low, f_nb, f_din, f_dend, f_dafter, f_busybad, f_rmin, f_rmax;
    logic [31:0] f_bits;

    task automatic wait_frame();
        logic prev;
        int   run;
        f_wait = 0; f_low = 0; f_nb = 0; f_din = 0; f_busybad = 0;
        f_bits = 0; f_rmin = 999; f_rmax = 0; f_dend = 0; f_dafter = 0;
        while (m_cs && f_wait < 200) begin
            @(negedge clk);
            f_wait++;
        end
        if (m_cs) begin
            chk("cs_fall_timeout", 1, 0);
            return;
        end
        prev = 1'b1;
        run  = 0;
        while (!m_cs && f_low < 2000) begin
            f_low++;
            if (m_done) f_din++;
            if (!m_busy) f_busybad++;
            if (m_sclk && !prev) begin
                f_bits = {f_bits[30:0], m_sdo};
                f_nb++;
            end
            if (!m_sclk) run++;
            else if (run != 0) begin
                if (run < f_rmin) f_rmin = run;
                if (run > f_rmax) f_rmax = run;
                run = 0;
            end
            prev = m_sclk;
            @(negedge clk);
        end
        f_dend = int'(m_done);
        @(negedge clk);
        f_dafter = int'(m_done);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] ebits, input int enb,
                               input int elow, input int erun);
        chk({tag, ".bits"},   f_bits, ebits);
        chk({tag, ".nbits"},  f_nb, enb);
        chk({tag, ".cs_low"}, f_low, elow);
        chk({tag, ".done_in"}, f_din, 0);
        chk({tag, ".done_end"}, f_dend, 1);
        chk({tag, ".done_after"}, f_dafter, 0);
        chk({tag, ".busy"},   f_busybad, 0);
        chk({tag, ".half_min"}, f_rmin, erun);
        chk({tag, ".half_max"}, f_rmax, erun);
    endtask

    task automatic quiet(input string tag, input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (!m_cs || m_done || m_busy) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; data = '0; ch = 1'b0; ch_c = '0;
        stb_a = 1'b0; stb_b = 1'b0; stb_c = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            inst = i;
            #1;
            chk("rst.sclk", m_sclk, 1); chk("rst.cs", m_cs, 1); chk("rst.sdo", m_sdo, 0);
            chk("rst.busy", m_busy, 0); chk("rst.done", m_done, 0); chk("rst.ovr", m_ovr, 0);
        end
        inst = 0;
        rst_n = 1'b1; en = 1'b1;

        // Single frame: address 1 then 0xA5 MSB-first
        strobe(0, 2'd1, 8'hA5);
        wait_frame();
        chk("t1.latency", f_wait, 1);
        check_frame("t1", 32'h1A5, 9, 19, 1);

        // ch0 then ch1 on consecutive cycles: back-to-back, 2 cs-high cycles between
        strobe2(1'b0, 8'h11, 1'b1, 8'h22);
        wait_frame();
        chk("t2a.latency", f_wait, 0);
        check_frame("t2a", 32'h011, 9, 19, 1);
        wait_frame();
        chk("t2b.gap", f_wait + 1, 2);
        check_frame("t2b", 32'h122, 9, 19, 1);

        // Reverse order: ch1 is the only pending one when the scheduler looks
        strobe2(1'b1, 8'h22, 1'b0, 8'h11);
        wait_frame();
        check_frame("t3a", 32'h122, 9, 19, 1);
        wait_frame();
        chk("t3b.gap", f_wait + 1, 2);
        check_frame("t3b", 32'h011, 9, 19, 1);

        // Both pending at once after ch0 was last served: ch1 must go first
        @(negedge clk); en = 1'b0;
        strobe(0, 2'd0, 8'h3C);
        strobe(0, 2'd1, 8'h5A);
        chk("t4.no_ovr", m_ovr, 0);
        @(negedge clk); en = 1'b1;
        wait_frame();
        chk("t4a.latency", f_wait, 1);
        check_frame("t4a", 32'h15A, 9, 19, 1);
        wait_frame();
        check_frame("t4b", 32'h03C, 9, 19, 1);

        // Refill of the slot being loaded in the same cycle: no overrun, both sent
        strobe2(1'b0, 8'h11, 1'b0, 8'h22);
        chk("t5.no_ovr", m_ovr, 0);
        wait_frame();
        check_frame("t5a", 32'h011, 9, 19, 1);
        wait_frame();
        check_frame("t5b", 32'h022, 9, 19, 1);

        // Overrun: second sample replaces the first, only one frame goes out
        @(negedge clk); en = 1'b0;
        strobe(0, 2'd0, 8'h10);
        chk("t6.ovr_first", m_ovr, 0);
        strobe(0, 2'd0, 8'h20);
        chk("t6.ovr_set", m_ovr, 1);
        @(negedge clk); en = 1'b1;
        wait_frame();
        check_frame("t6", 32'h020, 9, 19, 1);
        quiet("t6.single_frame", 10);
        chk("t6.ovr_sticky", m_ovr, 1);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk("t6.ovr_clear", m_ovr, 0);

        // New overrun coinciding with clear: overrun stays set
        en = 1'b0;
        strobe(0, 2'd1, 8'h01);
        @(negedge clk); data = 8'h02; ch = 1'b1; stb_a = 1'b1; clr = 1'b1;
        @(negedge clk); stb_a = 1'b0; clr = 1'b0;
        chk("t7.ovr_wins", m_ovr, 1);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        chk("t7.ovr_clear", m_ovr, 0);
        @(negedge clk); en = 1'b1;
        wait_frame();
        check_frame("t7", 32'h102, 9, 19, 1);
        quiet("t7.single_frame", 8);

        // Reset in bit 4 with another sample pending: everything dropped
        strobe(0, 2'd1, 8'hFF);
        strobe(0, 2'd0, 8'h11);
        begin
            int   rises = 0;
            int   guard = 0;
            logic prev  = m_sclk;
            while (rises < 4 && guard < 100) begin
                @(negedge clk);
                guard++;
                if (m_sclk && !prev) rises++;
                prev = m_sclk;
            end
            chk("t8.reach_bit4", rises, 4);
        end
        @(negedge clk);
        chk("t8.pre_sdo", m_sdo, 1);
        chk("t8.pre_cs", m_cs, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t8.cs", m_cs, 1); chk("t8.sclk", m_sclk, 1); chk("t8.sdo", m_sdo, 0);
        chk("t8.busy", m_busy, 0); chk("t8.done", m_done, 0);
        quiet("t8.no_frames", 30);

        // CLK_DIV=3, LSB-first sample
        inst = 1;
        strobe(1, 2'd0, 8'h01);
        wait_frame();
        chk("t9.latency", f_wait, 1);
        check_frame("t9", 32'h080, 9, 57, 3);

        // ADDR_BITS=2 with CHANNELS=2: channel 2 is ignored entirely
        inst = 2;
        strobe(2, 2'd2, 8'hFF);
        quiet("t10.ignored", 30);
        chk("t10.ovr", m_ovr, 0);
        strobe(2, 2'd2, 8'hAA);
        chk("t10.ovr_again", m_ovr, 0);
        quiet("t10.ignored2", 10);
        strobe(2, 2'd1, 8'h3C);
        wait_frame();
        chk("t10.latency", f_wait, 1);
        check_frame("t10", 32'h13C, 10, 21, 1);
        quiet("t10.no_more", 20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
